// File: rtl/add_sub.sv
// -----------------------------------------------------------------------------
// add_sub -- registered element-wise matrix adder / subtractor
//
// Purpose:
//   Computes m_out = m1 + m2 (select_op = 0) or m_out = m1 - m2 (select_op = 1)
//   independently for every element of a DIM x DIM matrix of unsigned
//   ELEM_W-bit values. The result is registered, so latency is one cycle and
//   throughput is one result per cycle while enable is high.
//
// Parameters:
//   ELEM_W    element width in bits (default 16)
//   DIM       matrix dimension, DIM x DIM elements (default 4)
//
// Ports (positional order m_out, m1, m2, select_op, enable, reset, clk):
//   m_out     out  DIM*DIM*ELEM_W  registered result matrix
//   m1        in   DIM*DIM*ELEM_W  operand matrix A
//   m2        in   DIM*DIM*ELEM_W  operand matrix B
//   select_op in   1               0 = A+B, 1 = A-B
//   enable    in   1               qualifies a compute cycle
//   reset     in   1               synchronous active-high reset
//   clk       in   1               clock, rising edge
//
// Element [row][col] occupies bits (row*DIM + col)*ELEM_W +: ELEM_W.
//
// Optional feature macro: ADD_SUB_SATURATE_EN
//   When defined, addition clamps to 2^ELEM_W-1 and subtraction clamps to 0
//   instead of wrapping modulo 2^ELEM_W.
// -----------------------------------------------------------------------------
module add_sub #(
  parameter int ELEM_W = 16,
  parameter int DIM    = 4
) (
  output logic [DIM*DIM*ELEM_W-1:0] m_out,
  input  logic [DIM*DIM*ELEM_W-1:0] m1,
  input  logic [DIM*DIM*ELEM_W-1:0] m2,
  input  logic                      select_op,
  input  logic                      enable,
  input  logic                      reset,
  input  logic                      clk
);

  localparam int N_ELEM = DIM * DIM;
  localparam int BUS_W  = N_ELEM * ELEM_W;

  logic [BUS_W-1:0] w_result;
  logic [BUS_W-1:0] r_m_out;

  // One independent arithmetic lane per element; lanes never share carries.
  genvar gi;
  generate
    for (gi = 0; gi < N_ELEM; gi++) begin : g_elem
      logic [ELEM_W-1:0] w_a;
      logic [ELEM_W-1:0] w_b;

      assign w_a = m1[gi*ELEM_W +: ELEM_W];
      assign w_b = m2[gi*ELEM_W +: ELEM_W];

`ifdef ADD_SUB_SATURATE_EN
      // One extra bit captures the carry-out (add) or borrow (sub).
      logic [ELEM_W:0] w_sum;
      logic [ELEM_W:0] w_diff;

      assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
      assign w_diff = {1'b0, w_a} - {1'b0, w_b};

      always_comb begin
        w_result[gi*ELEM_W +: ELEM_W] = '0;
        if (select_op) begin
          // Borrow set means B > A: clamp to zero.
          w_result[gi*ELEM_W +: ELEM_W] = w_diff[ELEM_W] ? '0 : w_diff[ELEM_W-1:0];
        end else begin
          // Carry set means overflow: clamp to all ones.
          w_result[gi*ELEM_W +: ELEM_W] = w_sum[ELEM_W] ? '1 : w_sum[ELEM_W-1:0];
        end
      end
`else
      // Native ELEM_W-bit arithmetic drops the carry/borrow, giving the
      // modulo-2^ELEM_W wrap directly.
      logic [ELEM_W-1:0] w_sum;
      logic [ELEM_W-1:0] w_diff;

      assign w_sum  = w_a + w_b;
      assign w_diff = w_a - w_b;

      assign w_result[gi*ELEM_W +: ELEM_W] = select_op ? w_diff : w_sum;
`endif
    end
  endgenerate

  // Reset wins over enable; with enable low the register simply holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_out <= '0;
    end else if (enable) begin
      r_m_out <= w_result;
    end
  end

  assign m_out = r_m_out;

endmodule

// File: tb/tb_add_sub.sv
// -----------------------------------------------------------------------------
// tb_add_sub -- self-checking bench for add_sub (default 16-bit, 4x4).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after the rising edge that consumed them.
// -----------------------------------------------------------------------------
module tb_add_sub;

  localparam int EW = 16;
  localparam int D  = 4;
  localparam int BW = D * D * EW;

  logic [BW-1:0] m_out;
  logic [BW-1:0] m1;
  logic [BW-1:0] m2;
  logic          select_op;
  logic          enable;
  logic          reset;
  logic          clk;

  int n_cmp;
  int n_err;

  add_sub #(.ELEM_W(EW), .DIM(D)) dut (
    .m_out     (m_out),
    .m1        (m1),
    .m2        (m2),
    .select_op (select_op),
    .enable    (enable),
    .reset     (reset),
    .clk       (clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each element treated as a plain integer, combined, then
  // reduced to the 16-bit range (wrap or clamp).
  function automatic logic [BW-1:0] model(input logic [BW-1:0] a,
                                          input logic [BW-1:0] b,
                                          input logic op);
    logic [BW-1:0] res;
    int x;
    int y;
    int z;
    res = '0;
    for (int e = 0; e < D * D; e++) begin
      x = {16'd0, a[e*EW +: EW]};
      y = {16'd0, b[e*EW +: EW]};
      z = op ? (x - y) : (x + y);
`ifdef ADD_SUB_SATURATE_EN
      if (z > 65535) z = 65535;
      if (z < 0)     z = 0;
`else
      z = z & 32'h0000_FFFF;
`endif
      res[e*EW +: EW] = z[15:0];
    end
    return res;
  endfunction

  function automatic logic [4*EW-1:0] mk_row(input int c0, input int c1,
                                             input int c2, input int c3);
    logic [EW-1:0] v0, v1, v2, v3;
    v0 = c0[EW-1:0];
    v1 = c1[EW-1:0];
    v2 = c2[EW-1:0];
    v3 = c3[EW-1:0];
    return {v3, v2, v1, v0};
  endfunction

  function automatic logic [BW-1:0] rand_mat();
    logic [BW-1:0] v;
    logic [31:0]   w;
    for (int k = 0; k < BW / 32; k++) begin
      w = $urandom;
      v[k*32 +: 32] = w;
    end
    // Occasionally pin elements to the extremes to hit carry/borrow cases.
    for (int e = 0; e < D * D; e++) begin
      case ($urandom_range(0, 7))
        0:       v[e*EW +: EW] = 16'hFFFF;
        1:       v[e*EW +: EW] = 16'h0000;
        default: ;
      endcase
    end
    return v;
  endfunction

  // Drive one set of inputs and advance to the next sampling point.
  task automatic drive(input logic [BW-1:0] a, input logic [BW-1:0] b,
                       input logic op, input logic en, input logic rst);
    m1        = a;
    m2        = b;
    select_op = op;
    enable    = en;
    reset     = rst;
    @(negedge clk);
  endtask

  logic [BW-1:0] mat_a;
  logic [BW-1:0] mat_b;

  task automatic test_reset();
    drive(rand_mat(), rand_mat(), 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (m_out !== '0) begin
      n_err++;
      $display("FAIL reset_clear: got %h want 0", m_out);
    end
    $display("reset: m_out=%h", m_out);
  endtask

  task automatic test_vectors();
    logic [BW-1:0] exp_add;
    logic [BW-1:0] exp_sub;
    mat_a = {mk_row(10, 7, 8, 7), mk_row(12, 10, 15, 14),
             mk_row(8, 9, 15, 5), mk_row(11, 14, 19, 18)};
    mat_b = {mk_row(8, 5, 7, 6), mk_row(6, 5, 4, 3),
             mk_row(7, 3, 8, 4), mk_row(5, 8, 9, 2)};
    exp_add = {mk_row(18, 12, 15, 13), mk_row(18, 15, 19, 17),
               mk_row(15, 12, 23, 9), mk_row(16, 22, 28, 20)};
    exp_sub = {mk_row(2, 2, 1, 1), mk_row(6, 5, 11, 11),
               mk_row(1, 6, 7, 1), mk_row(6, 6, 10, 16)};

    drive(mat_a, mat_b, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (m_out !== exp_sub) begin
      n_err++;
      $display("FAIL fixed_sub: got %h want %h", m_out, exp_sub);
    end
    $display("fixed sub: m_out=%h", m_out);

    drive(mat_a, mat_b, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (m_out !== exp_add) begin
      n_err++;
      $display("FAIL fixed_add: got %h want %h", m_out, exp_add);
    end
    $display("fixed add: m_out=%h", m_out);
  endtask

  // Runs right after test_vectors: m_out must keep the addition result.
  task automatic test_hold();
    logic [BW-1:0] held;
    held = {mk_row(18, 12, 15, 13), mk_row(18, 15, 19, 17),
            mk_row(15, 12, 23, 9), mk_row(16, 22, 28, 20)};
    for (int i = 0; i < 6; i++) begin
      drive(rand_mat(), rand_mat(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      n_cmp++;
      if (m_out !== held) begin
        n_err++;
        $display("FAIL hold_%0d: got %h want %h", i, m_out, held);
      end
      $display("hold %0d: m_out=%h", i, m_out);
    end
  endtask

  task automatic test_boundary();
    logic [EW-1:0] e0;
    logic [EW-1:0] e1;
    mat_a = '0;
    mat_b = '0;
    mat_a[0 +: EW]  = 16'hFFFF;
    mat_b[0 +: EW]  = 16'h0001;
    mat_a[EW +: EW] = 16'h1234;
    mat_b[EW +: EW] = 16'h0001;
    drive(mat_a, mat_b, 1'b0, 1'b1, 1'b0);
    e0 = m_out[0 +: EW];
    e1 = m_out[EW +: EW];
`ifdef ADD_SUB_SATURATE_EN
    n_cmp++;
    if (e0 !== 16'hFFFF) begin
      n_err++;
      $display("FAIL add_boundary: got %h want ffff", e0);
    end
`else
    n_cmp++;
    if (e0 !== 16'h0000) begin
      n_err++;
      $display("FAIL add_boundary: got %h want 0000", e0);
    end
`endif
    n_cmp++;
    if (e1 !== 16'h1235 || m_out[BW-1:2*EW] !== '0) begin
      n_err++;
      $display("FAIL add_neighbour: got %h want %h", m_out, model(mat_a, mat_b, 1'b0));
    end
    $display("add boundary: m_out=%h", m_out);

    mat_a[0 +: EW]  = 16'h0000;
    mat_b[0 +: EW]  = 16'h0001;
    mat_a[EW +: EW] = 16'h0005;
    mat_b[EW +: EW] = 16'h0001;
    drive(mat_a, mat_b, 1'b1, 1'b1, 1'b0);
    e0 = m_out[0 +: EW];
    e1 = m_out[EW +: EW];
`ifdef ADD_SUB_SATURATE_EN
    n_cmp++;
    if (e0 !== 16'h0000) begin
      n_err++;
      $display("FAIL sub_boundary: got %h want 0000", e0);
    end
`else
    n_cmp++;
    if (e0 !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sub_boundary: got %h want ffff", e0);
    end
`endif
    n_cmp++;
    if (e1 !== 16'h0004 || m_out[BW-1:2*EW] !== '0) begin
      n_err++;
      $display("FAIL sub_neighbour: got %h want %h", m_out, model(mat_a, mat_b, 1'b1));
    end
    $display("sub boundary: m_out=%h", m_out);
  endtask

  // Continuous enable with a random operation every cycle.
  task automatic test_back_to_back();
    logic          op;
    logic [BW-1:0] exp;
    for (int i = 0; i < 24; i++) begin
      mat_a = rand_mat();
      mat_b = rand_mat();
      op    = 1'($urandom_range(0, 1));
      exp   = model(mat_a, mat_b, op);
      drive(mat_a, mat_b, op, 1'b1, 1'b0);
      n_cmp++;
      if (m_out !== exp) begin
        n_err++;
        $display("FAIL b2b_%0d op=%0d: got %h want %h", i, op, m_out, exp);
      end
      $display("b2b %0d op=%0d: m_out=%h", i, op, m_out);
    end
  endtask

  // Random mix of enabled and idle cycles against a tracked expectation.
  task automatic test_random_enable();
    logic          op;
    logic          en;
    logic [BW-1:0] exp;
    exp = m_out === 'x ? '0 : '0;
    drive(rand_mat(), rand_mat(), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      mat_a = rand_mat();
      mat_b = rand_mat();
      op    = 1'($urandom_range(0, 1));
      en    = 1'($urandom_range(0, 1));
      if (en) exp = model(mat_a, mat_b, op);
      drive(mat_a, mat_b, op, en, 1'b0);
      n_cmp++;
      if (m_out !== exp) begin
        n_err++;
        $display("FAIL rand_%0d en=%0d op=%0d: got %h want %h", i, en, op, m_out, exp);
      end
      $display("rand %0d en=%0d op=%0d: m_out=%h", i, en, op, m_out);
    end
  endtask

  task automatic test_reset_priority();
    mat_a = rand_mat();
    mat_b = rand_mat();
    drive(mat_a, mat_b, 1'b0, 1'b1, 1'b0);
    drive(mat_a, mat_b, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (m_out !== '0) begin
      n_err++;
      $display("FAIL reset_priority: got %h want 0", m_out);
    end
    $display("reset priority: m_out=%h", m_out);
  endtask

  task automatic test_midstream_reset();
    logic [BW-1:0] exp;
    mat_a = rand_mat();
    mat_b = rand_mat();
    drive(mat_a, mat_b, 1'b1, 1'b1, 1'b0);
    drive(rand_mat(), rand_mat(), 1'b0, 1'b1, 1'b1);
    drive(mat_a, mat_b, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (m_out !== '0) begin
      n_err++;
      $display("FAIL post_reset_idle: got %h want 0", m_out);
    end
    $display("post reset idle: m_out=%h", m_out);
    exp = model(mat_a, mat_b, 1'b0);
    drive(mat_a, mat_b, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (m_out !== exp) begin
      n_err++;
      $display("FAIL post_reset_first: got %h want %h", m_out, exp);
    end
    $display("post reset first: m_out=%h", m_out);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    m1        = '0;
    m2        = '0;
    select_op = 1'b0;
    enable    = 1'b0;
    reset     = 1'b1;
    test_reset();
    test_vectors();
    test_hold();
    test_boundary();
    test_back_to_back();
    test_random_enable();
    test_reset_priority();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
